// File: rtl/ins_encoder_if.sv
// Handshake bus for ins_encoder: request side (instruction fields in) and
// delivery side (encoded instruction words out).
interface ins_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [1:0]  in_dst;
    logic [1:0]  in_src;
    logic [7:0]  in_imm;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_ins;

    // Producer/consumer side (testbench or upstream/downstream logic)
    modport master (
        output in_valid, in_op, in_dst, in_src, in_imm, in_flush, out_ready,
        input  in_ready, out_valid, out_ins
    );

    // Encoder side
    modport slave (
        input  in_valid, in_op, in_dst, in_src, in_imm, in_flush, out_ready,
        output in_ready, out_valid, out_ins
    );
endinterface

// File: rtl/ins_encoder.sv
// Instruction encoder: turns an opcode/register/immediate request into a
// 20-bit word {op, one-hot lhs, rhs}, buffers legal words in a small FIFO and
// drops illegal requests while recording them in err/ill_cnt.
module ins_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ins_encoder_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [3:0]               ill_cnt,
    output logic [7:0]               seq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Opcode legality: 1..10 always legal, shifts only by 0..8 bits.
    function automatic logic is_legal(input logic [3:0] op, input logic [7:0] imm);
        logic ok;
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10: ok = 1'b1;
            4'd11, 4'd12:                  ok = (imm <= 8'd8);
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Right-hand operand: one-hot register for register forms, raw immediate otherwise.
    function automatic logic [7:0] enc_rhs(input logic [3:0] op,
                                           input logic [1:0] src,
                                           input logic [7:0] imm);
        logic [7:0] r;
        case (op)
            4'd2, 4'd4, 4'd6, 4'd8, 4'd10: r = 8'd1 << src;
            default:                       r = imm;
        endcase
        return r;
    endfunction

    logic [19:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          push_hs;
    logic          legal;
    logic          push;
    logic          pop;
    logic [19:0]   word;

    // Handshake outputs derive from registered state; in_flush blocks intake.
    assign bus.in_ready  = (count < CW'(DEPTH)) && !bus.in_flush;
    assign bus.out_valid = (count != CW'(0));
    assign bus.out_ins   = bus.out_valid ? mem[rd_ptr] : 20'd0;

    // Decode the request and qualify push/pop strobes.
    always_comb begin
        push_hs = 1'b0;
        legal   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        word    = 20'd0;
        push_hs = bus.in_valid && bus.in_ready;
        legal   = is_legal(bus.in_op, bus.in_imm);
        push    = push_hs && legal;
        pop     = bus.out_valid && bus.out_ready && !bus.in_flush;
        word    = {bus.in_op, 8'd1 << bus.in_dst,
                   enc_rhs(bus.in_op, bus.in_src, bus.in_imm)};
    end

    // FIFO storage, pointers, occupancy and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
            ill_cnt <= 4'd0;
            seq     <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 20'd0;
            end
        end else if (bus.in_flush) begin
            // Buffered words are discarded; history counters survive.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PW'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                seq    <= seq + 8'd1;
            end else begin
                rd_ptr <= rd_ptr;
                seq    <= seq;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Illegal requests handshake but are only recorded, never stored.
            if (push_hs && !legal) begin
                err <= 1'b1;
                if (ill_cnt != 4'd15) begin
                    ill_cnt <= ill_cnt + 4'd1;
                end else begin
                    ill_cnt <= ill_cnt;
                end
            end else begin
                err     <= err;
                ill_cnt <= ill_cnt;
            end
        end
    end
endmodule

// File: tb/tb_ins_encoder.sv
// Directed self-checking bench for ins_encoder (DEPTH = 4).
module tb_ins_encoder;
    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       err;
    logic [3:0] ill_cnt;
    logic [7:0] seq;
    int         n_cmp;
    int         n_bad;

    ins_encoder_if bus ();

    ins_encoder #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count   (count),
        .err     (err),
        .ill_cnt (ill_cnt),
        .seq     (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] src, input logic [7:0] imm);
        bus.in_op    = op;
        bus.in_dst   = dst;
        bus.in_src   = src;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
    endtask

    task automatic push(input logic [3:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic [7:0] imm);
        set_req(op, dst, src, imm);
        tick();
        bus.in_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_dst = 2'd0; bus.in_src = 2'd0;
        bus.in_imm = 8'd0; bus.in_flush = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_ill_cnt", ill_cnt, 0);
        chk("rst_seq", seq, 0);
        chk("rst_out_ins", bus.out_ins, 0);

        // Immediate forms, order and seq
        push(4'd1, 2'd0, 2'd0, 8'h02);
        chk("imm1_valid", bus.out_valid, 1);
        chk("imm1_ins", bus.out_ins, 32'h10102);
        chk("imm1_count", count, 1);
        push(4'd3, 2'd0, 2'd0, 8'h0F);
        chk("imm2_count", count, 2);
        chk("imm2_head", bus.out_ins, 32'h10102);
        bus.out_ready = 1'b1;
        tick();
        chk("pop1_ins", bus.out_ins, 32'h3010F);
        chk("pop1_seq", seq, 1);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("pop2_valid", bus.out_valid, 0);
        chk("pop2_seq", seq, 2);
        chk("pop2_count", count, 0);

        // Register form and shift
        push(4'd4, 2'd2, 2'd3, 8'hFF);
        chk("reg_ins", bus.out_ins, 32'h40408);
        push(4'd12, 2'd3, 2'd0, 8'h03);
        bus.out_ready = 1'b1;
        tick();
        chk("shl_ins", bus.out_ins, 32'hC0803);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("reg_drain_count", count, 0);
        chk("reg_drain_seq", seq, 4);
        // Empty: out_ready has no effect
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("empty_pop_seq", seq, 4);
        chk("empty_pop_count", count, 0);

        // Illegal requests
        push(4'd13, 2'd0, 2'd0, 8'h00);
        push(4'd11, 2'd1, 2'd0, 8'h09);
        chk("ill_count", count, 0);
        chk("ill_valid", bus.out_valid, 0);
        chk("ill_err", err, 1);
        chk("ill_cnt2", ill_cnt, 2);
        push(4'd11, 2'd1, 2'd0, 8'h08);
        chk("shr8_legal_ins", bus.out_ins, 32'hB0208);
        chk("shr8_ill_cnt", ill_cnt, 2);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("shr8_drain_seq", seq, 5);
        set_req(4'd14, 2'd0, 2'd0, 8'h00);
        for (int i = 0; i < 16; i++) tick();
        bus.in_valid = 1'b0;
        #1;
        chk("ill_sat", ill_cnt, 15);
        chk("ill_sat_count", count, 0);

        // Full buffer and stall
        push(4'd1, 2'd0, 2'd0, 8'h11);
        push(4'd1, 2'd0, 2'd0, 8'h22);
        push(4'd1, 2'd0, 2'd0, 8'h33);
        push(4'd1, 2'd0, 2'd0, 8'h44);
        set_req(4'd1, 2'd0, 2'd0, 8'h55);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", bus.in_ready, 0);
        tick();
        chk("stall_count", count, 4);
        bus.out_ready = 1'b1;
        #1;
        chk("full_head", bus.out_ins, 32'h10111);
        tick();
        chk("after_pop_ready", bus.in_ready, 1);
        chk("after_pop_count", count, 3);
        chk("drain_ins2", bus.out_ins, 32'h10122);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("pushpop_count", count, 3);
        chk("drain_ins3", bus.out_ins, 32'h10133);
        tick();
        chk("drain_ins4", bus.out_ins, 32'h10144);
        tick();
        chk("drain_ins5", bus.out_ins, 32'h10155);
        tick();
        chk("drain_empty", bus.out_valid, 0);
        chk("drain_seq", seq, 10);
        bus.out_ready = 1'b0;

        // Simultaneous push/pop across the pointer wrap
        push(4'd2, 2'd1, 2'd2, 8'h00);
        push(4'd6, 2'd3, 2'd0, 8'h00);
        chk("sim_pre_count", count, 2);
        bus.out_ready = 1'b1;
        set_req(4'd8, 2'd0, 2'd1, 8'h00);
        tick();
        chk("sim1_count", count, 2);
        chk("sim1_ins", bus.out_ins, 32'h60801);
        set_req(4'd10, 2'd2, 2'd2, 8'h00);
        tick();
        chk("sim2_count", count, 2);
        chk("sim2_ins", bus.out_ins, 32'h80102);
        // Illegal push while popping: count drops by one
        set_req(4'd15, 2'd0, 2'd0, 8'h00);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("illpop_count", count, 1);
        chk("illpop_ins", bus.out_ins, 32'hA0404);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("sim_drain_count", count, 0);
        chk("sim_drain_seq", seq, 14);

        // Flush keeps err/ill_cnt/seq; concurrent pop not counted
        push(4'd1, 2'd1, 2'd0, 8'h01);
        push(4'd1, 2'd1, 2'd0, 8'h02);
        push(4'd1, 2'd1, 2'd0, 8'h03);
        chk("preflush_count", count, 3);
        bus.in_flush  = 1'b1;
        bus.out_ready = 1'b1;
        set_req(4'd1, 2'd0, 2'd0, 8'h66);
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        tick();
        bus.in_flush = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_err", err, 1);
        chk("flush_seq", seq, 14);
        chk("flush_ill", ill_cnt, 15);
        push(4'd1, 2'd0, 2'd0, 8'h77);
        chk("postflush_ins", bus.out_ins, 32'h10177);
        push(4'd1, 2'd0, 2'd0, 8'h78);
        push(4'd1, 2'd0, 2'd0, 8'h79);

        // Reset mid-transfer
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_req(4'd1, 2'd0, 2'd0, 8'h7A);
        tick();
        rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("rst2_count", count, 0);
        chk("rst2_err", err, 0);
        chk("rst2_seq", seq, 0);
        chk("rst2_ill", ill_cnt, 0);
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_ins", bus.out_ins, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
